// File: rtl/vga_timing_monitor.sv
// Receive-side VGA timing checker: measures line/frame periods and sync widths,
// counts lit pixels per frame, and reports lock status plus a saturating error count.
module vga_timing_monitor #(
  parameter int H_TOTAL         = 800,
  parameter int H_SYNC          = 96,
  parameter int V_TOTAL         = 525,
  parameter int V_SYNC          = 2,
  parameter int LOCK_FRAMES     = 2,
  parameter int SYNC_ACTIVE_LOW = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        hsync,
  input  logic        vsync,
  input  logic        red,
  input  logic        green,
  input  logic        blue,
  output logic [10:0] h_period,
  output logic [10:0] h_width,
  output logic [9:0]  v_period,
  output logic [9:0]  v_width,
  output logic [18:0] lit_pixels,
  output logic [7:0]  err_count,
  output logic        frame_tick,
  output logic        locked
);

  localparam logic        POL_C     = (SYNC_ACTIVE_LOW != 0);
  localparam logic [10:0] H_TOTAL_C = 11'(H_TOTAL);
  localparam logic [10:0] H_SYNC_C  = 11'(H_SYNC);
  localparam logic [9:0]  V_TOTAL_C = 10'(V_TOTAL);
  localparam logic [9:0]  V_SYNC_C  = 10'(V_SYNC);
  localparam logic [7:0]  LOCK_C    = 8'(LOCK_FRAMES);
  localparam logic [10:0] H_MAX_C   = 11'h7FF;
  localparam logic [9:0]  V_MAX_C   = 10'h3FF;
  localparam logic [18:0] PIX_MAX_C = 19'h7FFFF;
  localparam logic [7:0]  ERR_MAX_C = 8'hFF;

  logic        h_act_r, v_act_r, pix_r;
  logic        h_prev_r, v_prev_r;
  logic        h_rise_s, h_fall_s, v_rise_s, v_fall_s;
  logic [10:0] h_cnt_r, hw_cnt_r;
  logic [9:0]  v_cnt_r, vw_cnt_r;
  logic [18:0] pix_cnt_r;
  logic        h_armed_r, v_armed_r, hw_valid_r, vw_valid_r;
  logic        frame_ok_r;
  logic [7:0]  good_frames_r;

  logic [10:0] h_cnt_inc_s, hw_cnt_inc_s;
  logic [9:0]  v_cnt_inc_s, vw_cnt_inc_s;
  logic [18:0] pix_cnt_inc_s;
  logic        h_per_err_s, h_wid_err_s, v_per_err_s, v_wid_err_s;
  logic        h_to_s, v_to_s, err_s;
  logic [7:0]  gf_next_s;
  logic        fok_next_s, lock_next_s;

  assign h_rise_s = h_act_r & ~h_prev_r;
  assign h_fall_s = ~h_act_r & h_prev_r;
  assign v_rise_s = v_act_r & ~v_prev_r;
  assign v_fall_s = ~v_act_r & v_prev_r;

  // Input sampling and one-cycle history for edge detection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_act_r  <= 1'b0;
      v_act_r  <= 1'b0;
      pix_r    <= 1'b0;
      h_prev_r <= 1'b0;
      v_prev_r <= 1'b0;
    end else begin
      h_act_r  <= hsync ^ POL_C;
      v_act_r  <= vsync ^ POL_C;
      pix_r    <= red | green | blue;
      h_prev_r <= h_act_r;
      v_prev_r <= v_act_r;
    end
  end

  // Saturating increments, per-check errors and lock bookkeeping for this cycle
  always_comb begin
    h_cnt_inc_s   = (h_cnt_r == H_MAX_C) ? H_MAX_C : h_cnt_r + 11'd1;
    hw_cnt_inc_s  = (hw_cnt_r == H_MAX_C) ? H_MAX_C : hw_cnt_r + 11'd1;
    v_cnt_inc_s   = (v_cnt_r == V_MAX_C) ? V_MAX_C : v_cnt_r + 10'd1;
    vw_cnt_inc_s  = (vw_cnt_r == V_MAX_C) ? V_MAX_C : vw_cnt_r + 10'd1;
    pix_cnt_inc_s = (pix_cnt_r == PIX_MAX_C) ? PIX_MAX_C : pix_cnt_r + 19'd1;

    h_per_err_s = h_rise_s & h_armed_r & (h_cnt_inc_s != H_TOTAL_C);
    h_wid_err_s = h_fall_s & hw_valid_r & (hw_cnt_r != H_SYNC_C);
    v_per_err_s = v_rise_s & v_armed_r & (v_cnt_r != V_TOTAL_C);
    v_wid_err_s = v_fall_s & vw_valid_r & (vw_cnt_r != V_SYNC_C);
    // Timeouts fire only on the step into saturation, so a stuck sync costs one error
    h_to_s = ~h_rise_s & (h_cnt_r == (H_MAX_C - 11'd1));
    v_to_s = h_rise_s & ~v_rise_s & (v_cnt_r == (V_MAX_C - 10'd1));
    err_s  = h_per_err_s | h_wid_err_s | v_per_err_s | v_wid_err_s | h_to_s | v_to_s;

    gf_next_s   = good_frames_r;
    fok_next_s  = frame_ok_r;
    lock_next_s = locked;
    if (err_s) begin
      gf_next_s   = 8'd0;
      fok_next_s  = 1'b0;
      lock_next_s = 1'b0;
    end else if (v_rise_s) begin
      if (v_armed_r && frame_ok_r && (good_frames_r < LOCK_C)) begin
        gf_next_s = good_frames_r + 8'd1;
      end else begin
        gf_next_s = good_frames_r;
      end
      fok_next_s  = 1'b1;
      lock_next_s = (gf_next_s >= LOCK_C);
    end else begin
      gf_next_s   = good_frames_r;
      fok_next_s  = frame_ok_r;
      lock_next_s = locked;
    end
  end

  // Horizontal period and sync-width measurement
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_cnt_r  <= 11'd0;
      hw_cnt_r <= 11'd0;
      h_period <= 11'd0;
      h_width  <= 11'd0;
    end else begin
      if (h_rise_s) begin
        h_period <= h_cnt_inc_s;
        h_cnt_r  <= 11'd0;
      end else begin
        h_cnt_r  <= h_cnt_inc_s;
      end
      if (h_act_r) begin
        hw_cnt_r <= h_rise_s ? 11'd1 : hw_cnt_inc_s;
      end else begin
        hw_cnt_r <= 11'd0;
      end
      if (h_fall_s) begin
        h_width <= hw_cnt_r;
      end
    end
  end

  // Vertical period and sync-width measurement, in lines
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v_cnt_r  <= 10'd0;
      vw_cnt_r <= 10'd0;
      v_period <= 10'd0;
      v_width  <= 10'd0;
    end else begin
      // An hsync edge coincident with the vsync edge belongs to the new frame
      if (v_rise_s) begin
        v_period <= v_cnt_r;
        v_cnt_r  <= h_rise_s ? 10'd1 : 10'd0;
        vw_cnt_r <= h_rise_s ? 10'd1 : 10'd0;
      end else begin
        if (h_rise_s) begin
          v_cnt_r <= v_cnt_inc_s;
        end
        if (h_rise_s && v_act_r) begin
          vw_cnt_r <= vw_cnt_inc_s;
        end
      end
      if (v_fall_s) begin
        v_width <= vw_cnt_r;
      end
    end
  end

  // Lit-pixel accumulation, published once per frame
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pix_cnt_r  <= 19'd0;
      lit_pixels <= 19'd0;
    end else if (v_rise_s) begin
      lit_pixels <= pix_cnt_r;
      pix_cnt_r  <= {18'd0, pix_r};
    end else if (pix_r) begin
      pix_cnt_r  <= pix_cnt_inc_s;
    end
  end

  // Arming: the first interval after reset is never checked
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_armed_r  <= 1'b0;
      v_armed_r  <= 1'b0;
      hw_valid_r <= 1'b0;
      vw_valid_r <= 1'b0;
    end else begin
      if (h_rise_s) begin
        h_armed_r  <= 1'b1;
        hw_valid_r <= h_armed_r;
      end
      if (v_rise_s) begin
        v_armed_r  <= 1'b1;
        vw_valid_r <= v_armed_r;
      end
    end
  end

  // Error counting, clean-frame tracking, lock and frame tick
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_count     <= 8'd0;
      good_frames_r <= 8'd0;
      frame_ok_r    <= 1'b0;
      locked        <= 1'b0;
      frame_tick    <= 1'b0;
    end else begin
      if (err_s && (err_count != ERR_MAX_C)) begin
        err_count <= err_count + 8'd1;
      end
      good_frames_r <= gf_next_s;
      frame_ok_r    <= fok_next_s;
      locked        <= lock_next_s;
      frame_tick    <= v_rise_s;
    end
  end

endmodule
